bcd_serial_addsub: RTL and testbench

Digit-serial 4-digit BCD adder/subtractor controller. It latches two 16-bit packed-BCD operands on a start handshake and drives one shared single-digit BCD adder stage across four clock cycles, least-significant digit first. For subtraction it applies the nines complement to B per digit. The result, carry/no-borrow flag and invalid-digit flag are presented with a one-cycle done pulse. It is the sequenced, area-reduced counterpart of the parallel four-stage BCD add/sub datapath, and the front end that calculator/control logic uses to issue BCD arithmetic.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 92 +++++++++
 tb/tb_bcd_serial_addsub.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD add/subtract block.
// Holds the controller state encoding, digit-count constants and the nines-complement helper.
package bcd_pkg;

  localparam int          BCD_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wraps modulo 16 for invalid digits so the result stays deterministic.
  function automatic logic [3:0] nines_comp(input logic [3:0] dig);
    return BCD_MAX - dig;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with +6 correction, shared across all digit cycles.
// Purely combinational; no storage or handshake.
module bcd_digit_add (
  input  logic       cin,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] z;
  logic [4:0] zc;

  always_comb begin
    z  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    zc = z + 5'd6;
    if (z < 5'd10) begin
      {cout, s} = z;
    end else begin
      {cout, s} = zc;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial 4-digit BCD add/subtract controller: LSD first, one digit per clock.
// Result appears with done four edges after the accepting edge; start is ignored while busy.
module bcd_serial_addsub
  import bcd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    add_sub,
  input  logic [4*BCD_DIGITS-1:0] a,
  input  logic [4*BCD_DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] d,
  output logic                    carryout,
  output logic                    err
);

  localparam int W = 4 * BCD_DIGITS;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q;
  logic [W-1:0]   a_q, b_q, d_q;
  logic           sub_q, carry_q, carryout_q, err_q;

  logic [3:0]     x, b_dig, y, s;
  logic           c;
  logic           accept;

  assign x      = a_q[{cnt_q, 2'b00} +: 4];
  assign b_dig  = b_q[{cnt_q, 2'b00} +: 4];
  assign y      = sub_q ? nines_comp(b_dig) : b_dig;
  assign accept = start && (state_q != RUN);

  bcd_digit_add u_digit (
    .cin  (carry_q),
    .x    (x),
    .y    (y),
    .s    (s),
    .cout (c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 2'd3) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is A + nines(B) + 1, so the carry seeds with add_sub.
        a_q        <= a;
        b_q        <= b;
        sub_q      <= add_sub;
        carry_q    <= add_sub;
        cnt_q      <= 2'd0;
        d_q        <= '0;
        carryout_q <= 1'b0;
        err_q      <= 1'b0;
      end else if (state_q == RUN) begin
        d_q[{cnt_q, 2'b00} +: 4] <= s;
        carry_q    <= c;
        carryout_q <= c;
        err_q      <= err_q | (x > BCD_MAX) | (b_dig > BCD_MAX);
        cnt_q      <= cnt_q + 2'd1;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign d        = d_q;
  assign carryout = carryout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed plus randomized bench for bcd_serial_addsub against a decimal-arithmetic reference.
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        add_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        carryout;
  logic        err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .add_sub  (add_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .d        (d),
    .carryout (carryout),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // Returns {err, carry, d}. Valid operands use plain decimal arithmetic;
  // operands with a bad digit fall back to the per-digit formula.
  function automatic logic [17:0] ref_model(input logic [15:0] av, input logic [15:0] bv,
                                            input logic op);
    logic        bad;
    logic        cy;
    logic [15:0] r;
    int          sum, diff, cin, xd, bd, yd, z, t;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    if (!bad) begin
      if (!op) begin
        sum = bcd2int(av) + bcd2int(bv);
        cy  = (sum >= 10000);
        r   = int2bcd(sum % 10000);
      end else begin
        diff = bcd2int(av) - bcd2int(bv);
        cy   = (diff >= 0);
        r    = int2bcd(diff < 0 ? diff + 10000 : diff);
      end
    end else begin
      cin = op ? 1 : 0;
      r   = '0;
      for (int i = 0; i < 4; i++) begin
        xd = int'(av[4*i +: 4]);
        bd = int'(bv[4*i +: 4]);
        yd = op ? ((9 - bd + 16) % 16) : bd;
        z  = xd + yd + cin;
        if (z < 10) begin
          r[4*i +: 4] = 4'(z);
          cin = 0;
        end else begin
          t = (z + 6) % 32;
          r[4*i +: 4] = 4'(t % 16);
          cin = t / 16;
        end
      end
      cy = (cin != 0);
    end
    return {bad, cy, r};
  endfunction

  // Launches one operation and checks latency, result and pulse width.
  // With inject set, a second start with other operands is pulsed mid-RUN.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic op, input bit inject);
    logic [17:0] exp;
    int          edges;
    exp     = ref_model(av, bv, op);
    a       = av;
    b       = bv;
    add_sub = op;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < 10) begin
      if (inject && edges == 1) begin
        start   = 1'b1;
        a       = 16'h9999;
        b       = 16'h9999;
        add_sub = ~op;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check({tag, "_latency"}, edges, 4);
    check({tag, "_d"}, d, exp[15:0]);
    check({tag, "_carry"}, carryout, exp[16]);
    check({tag, "_err"}, err, exp[17]);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, d, exp[15:0]);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [17:0] exp;
    int          last, pulses, waited;

    rst     = 1'b1;
    start   = 1'b1;
    add_sub = 1'b0;
    a       = 16'h1111;
    b       = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_carry", carryout, 0);
    check("rst_err", err, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0);
    run_op("sub_1234_5000", 16'h1234, 16'h5000, 1'b1, 1'b0);
    run_op("sub_0000_0000", 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("ignore_start", 16'h0456, 16'h0321, 1'b0, 1'b1);
    run_op("bad_digit", 16'h12A4, 16'h0000, 1'b0, 1'b0);
    run_op("after_bad", 16'h0042, 16'h0058, 1'b0, 1'b0);

    // Start held high: one result every five cycles.
    a       = 16'h2468;
    b       = 16'h1357;
    add_sub = 1'b1;
    exp     = ref_model(16'h2468, 16'h1357, 1'b1);
    start   = 1'b1;
    last    = -1;
    pulses  = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        check("held_period", cyc - last, (last < 0) ? cyc + 1 : 5);
        check("held_d", d, exp[15:0]);
        last = cyc;
        pulses++;
      end
    end
    check("held_pulses", pulses, 5);
    start  = 1'b0;
    waited = 0;
    while (!done && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("held_drain", done, 1);
    @(posedge clk); #1;

    // Reset in the second RUN cycle aborts without a done pulse.
    a       = 16'h8765;
    b       = 16'h4321;
    add_sub = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_carry", carryout, 0);
    check("abort_err", err, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op("post_abort", 16'h8765, 16'h4321, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) begin
        ra[4*k +: 4] = 4'($urandom_range(0, 9));
        rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      run_op("rand_valid", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ra[4*(i % 4) +: 4] = 4'($urandom_range(10, 15));
      run_op("rand_bad", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
